// File: rtl/snes_port_reader_pkg.sv
// Shared definitions for the SNES serial port reader and its port-side emitter counterpart:
// FSM encoding, frame lengths, pad bit positions and the word-finishing helper.
package snes_port_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SPD_LO = 3'd2,
        ST_SPD_HI = 3'd3,
        ST_BIT_LO = 3'd4,
        ST_BIT_HI = 3'd5,
        ST_FIN    = 3'd6
    } state_t;

    localparam logic [5:0] BITS16 = 6'd16;
    localparam logic [5:0] BITS32 = 6'd32;

    localparam int PAD_B     = 15;
    localparam int PAD_Y     = 14;
    localparam int PAD_SEL   = 13;
    localparam int PAD_START = 12;
    localparam int PAD_UP    = 11;
    localparam int PAD_DOWN  = 10;
    localparam int PAD_LEFT  = 9;
    localparam int PAD_RIGHT = 8;
    localparam int PAD_A     = 7;
    localparam int PAD_X     = 6;
    localparam int PAD_L     = 5;
    localparam int PAD_R     = 4;

    // Pad frames only ever fill the low half; the mask keeps the upper half clean regardless.
    function automatic logic [31:0] finish_word(input logic [31:0] sh, input logic [5:0] nbits);
        return (nbits == BITS32) ? sh : {16'h0000, sh[15:0]};
    endfunction

endpackage

// File: rtl/snes_port_reader_sync2.sv
// Two-flop synchroniser for the asynchronous controller data lines.
module snes_port_reader_sync2 #(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_p0;

    // Reset to the idle (released, pulled-high) level of the lines.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            d_p0 <= '1;
            q    <= '1;
        end else begin
            d_p0 <= d;
            q    <= d_p0;
        end
    end

endmodule

// File: rtl/snes_port_reader.sv
// Console-side SNES controller port reader: drives LATCH/CLK, shifts in both data lines
// and publishes de-inverted 16-bit (pad) or 32-bit (mouse) words atomically.
module snes_port_reader
    import snes_port_reader_pkg::*;
#(
    parameter int CLK_DIV      = 6,
    parameter int LATCH_CYCLES = 12
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        MODE32,
    input  logic [1:0]  SPEED_CYC,
    input  logic [1:0]  PORT_DI,
    output logic        PORT_LATCH,
    output logic        PORT_CLK,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] DATA0,
    output logic [31:0] DATA1
);

    localparam int CW = $clog2(CLK_DIV + LATCH_CYCLES);
    localparam logic [CW-1:0] LAT_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [5:0]    bit_cnt;
    logic [5:0]    nbits;
    logic [1:0]    spd_left;
    logic [31:0]   sh0;
    logic [31:0]   sh1;
    logic [1:0]    di_s;

    snes_port_reader_sync2 #(.WIDTH(2)) u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (PORT_DI),
        .q     (di_s)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            nbits      <= BITS16;
            spd_left   <= '0;
            sh0        <= '0;
            sh1        <= '0;
            PORT_LATCH <= 1'b0;
            PORT_CLK   <= 1'b1;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            DATA0      <= '0;
            DATA1      <= '0;
        end else begin
            DONE <= 1'b0;
            cnt  <= cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (START) begin
                        state      <= ST_LATCH;
                        nbits      <= MODE32 ? BITS32 : BITS16;
                        spd_left   <= SPEED_CYC;
                        bit_cnt    <= '0;
                        sh0        <= '0;
                        sh1        <= '0;
                        PORT_LATCH <= 1'b1;
                        PORT_CLK   <= 1'b1;
                        BUSY       <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (cnt == LAT_LAST) begin
                        cnt      <= '0;
                        PORT_CLK <= 1'b0;
                        if (spd_left != 2'd0) begin
                            state <= ST_SPD_LO;
                        end else begin
                            state      <= ST_BIT_LO;
                            PORT_LATCH <= 1'b0;
                        end
                    end
                end
                // Speed-step pulses: clocked with latch still high, nothing sampled.
                ST_SPD_LO: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        PORT_CLK <= 1'b1;
                        spd_left <= spd_left - 2'd1;
                        state    <= ST_SPD_HI;
                    end
                end
                ST_SPD_HI: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        PORT_CLK <= 1'b0;
                        if (spd_left == 2'd0) begin
                            state      <= ST_BIT_LO;
                            PORT_LATCH <= 1'b0;
                        end else begin
                            state <= ST_SPD_LO;
                        end
                    end
                end
                // Sample at the end of the low phase, just before the rising edge advances the device.
                ST_BIT_LO: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        PORT_CLK <= 1'b1;
                        sh0      <= {sh0[30:0], ~di_s[0]};
                        sh1      <= {sh1[30:0], ~di_s[1]};
                        bit_cnt  <= bit_cnt + 6'd1;
                        state    <= ST_BIT_HI;
                    end
                end
                ST_BIT_HI: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (bit_cnt == nbits) begin
                            state <= ST_FIN;
                            DATA0 <= finish_word(sh0, nbits);
                            DATA1 <= finish_word(sh1, nbits);
                            DONE  <= 1'b1;
                        end else begin
                            state    <= ST_BIT_LO;
                            PORT_CLK <= 1'b0;
                        end
                    end
                end
                ST_FIN: begin
                    cnt   <= '0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
